// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath: 2 to 5 cycles per instruction.
// No backpressure; pcen and illegal are the only outputs that also depend on inputs.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t cur;
  state_t nxt;
  logic   pcwrite;
  logic   branch;
  logic   legal_op;

  assign state    = cur;
  assign legal_op = (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
                    (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEXEC;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      end
      // op is held by the IR here, so only lw or sw can reach this state
      S_MEMADR: begin
        if (op == OP_LW)      nxt = S_MEMRD;
        else if (op == OP_SW) nxt = S_MEMWR;
        else                  nxt = S_FETCH;
      end
      S_MEMRD:    nxt = S_MEMWB;
      S_EXEC:     nxt = S_ALUWB;
      S_ADDIEXEC: nxt = S_ADDIWB;
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (cur)
      S_FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen    = pcwrite | (branch & zero);
  assign illegal = (cur == S_DECODE) && !legal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class state by state.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcen, illegal;
  logic [3:0] state;
  logic [14:0] ctl;

  int total = 0;
  int bad   = 0;
  logic rw_seen;
  logic watch;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
    .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsrc,pcen,illegal}
  assign ctl = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, aluop, pcsrc, pcen, illegal};

  localparam logic [14:0] C_FETCH  = 15'b0010000_01_00_00_1_0;
  localparam logic [14:0] C_DECODE = 15'b0000000_11_00_00_0_0;
  localparam logic [14:0] C_DECILL = 15'b0000000_11_00_00_0_1;
  localparam logic [14:0] C_MEMADR = 15'b0000001_10_00_00_0_0;
  localparam logic [14:0] C_MEMRD  = 15'b1000000_00_00_00_0_0;
  localparam logic [14:0] C_MEMWB  = 15'b0000110_00_00_00_0_0;
  localparam logic [14:0] C_MEMWR  = 15'b1100000_00_00_00_0_0;
  localparam logic [14:0] C_EXEC   = 15'b0000001_00_10_00_0_0;
  localparam logic [14:0] C_ALUWB  = 15'b0001010_00_00_00_0_0;
  localparam logic [14:0] C_BR_Z0  = 15'b0000001_00_01_01_0_0;
  localparam logic [14:0] C_BR_Z1  = 15'b0000001_00_01_01_1_0;
  localparam logic [14:0] C_ADDIWB = 15'b0000010_00_00_00_0_0;
  localparam logic [14:0] C_JUMP   = 15'b0000000_00_00_10_1_0;

  always @(negedge clk) begin
    if (watch && (regwrite || memwrite)) rw_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then check state code and full control vector
  task automatic cyc(input string tag, input logic [3:0] s, input logic [14:0] c);
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".ctl"}, 32'(ctl), 32'(c));
  endtask

  initial begin
    rst = 1'b1; op = 6'b000000; zero = 1'b0; watch = 1'b0; rw_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.ctl", 32'(ctl), 32'(C_FETCH));
    rst = 1'b0;
    chk("rel.pcsrc", 32'(pcsrc), 32'd0);

    // lw: 0,1,2,3,4,0
    op = 6'b100011;
    cyc("lw1", 4'd1, C_DECODE);
    cyc("lw2", 4'd2, C_MEMADR);
    cyc("lw3", 4'd3, C_MEMRD);
    cyc("lw4", 4'd4, C_MEMWB);
    cyc("lw0", 4'd0, C_FETCH);

    // sw: 0,1,2,5,0
    op = 6'b101011;
    cyc("sw1", 4'd1, C_DECODE);
    cyc("sw2", 4'd2, C_MEMADR);
    cyc("sw5", 4'd5, C_MEMWR);
    cyc("sw0", 4'd0, C_FETCH);

    // R-type: 0,1,6,7,0
    op = 6'b000000;
    cyc("r1", 4'd1, C_DECODE);
    cyc("r6", 4'd6, C_EXEC);
    cyc("r7", 4'd7, C_ALUWB);
    cyc("r0", 4'd0, C_FETCH);

    // addi: 0,1,9,10,0
    op = 6'b001000;
    cyc("ad1", 4'd1, C_DECODE);
    cyc("ad9", 4'd9, C_MEMADR);
    cyc("ad10", 4'd10, C_ADDIWB);
    cyc("ad0", 4'd0, C_FETCH);

    // beq not taken, then zero toggled inside BRANCH
    op = 6'b000100; zero = 1'b0;
    cyc("bq1", 4'd1, C_DECODE);
    cyc("bq8", 4'd8, C_BR_Z0);
    zero = 1'b1; #1;
    chk("bq8.zup.pcen", 32'(pcen), 32'd1);
    zero = 1'b0; #1;
    chk("bq8.zdn.pcen", 32'(pcen), 32'd0);
    cyc("bq0", 4'd0, C_FETCH);

    // beq taken; zero high in DECODE must not raise pcen
    zero = 1'b1;
    cyc("bt1", 4'd1, C_DECODE);
    cyc("bt8", 4'd8, C_BR_Z1);
    zero = 1'b0; #1;
    chk("bt8.zdn.pcen", 32'(pcen), 32'd0);
    cyc("bt0", 4'd0, C_FETCH);

    // j: 0,1,11,0
    op = 6'b000010;
    cyc("j1", 4'd1, C_DECODE);
    cyc("j11", 4'd11, C_JUMP);
    cyc("j0", 4'd0, C_FETCH);

    // unsupported opcode: 2 cycles, illegal pulse in DECODE only
    op = 6'b111111;
    cyc("il1", 4'd1, C_DECILL);
    cyc("il0", 4'd0, C_FETCH);

    // reset in MEMRD of lw abandons the instruction
    op = 6'b100011;
    cyc("mr1", 4'd1, C_DECODE);
    cyc("mr2", 4'd2, C_MEMADR);
    cyc("mr3", 4'd3, C_MEMRD);
    rst = 1'b1; watch = 1'b1;
    cyc("mrrst", 4'd0, C_FETCH);
    cyc("mrhold", 4'd0, C_FETCH);
    rst = 1'b0; op = 6'b111111;
    cyc("mra1", 4'd1, C_DECILL);
    cyc("mra0", 4'd0, C_FETCH);
    watch = 1'b0;
    chk("mr.nowrite", 32'(rw_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
